hamming_encoder_tx: RTL and testbench

Byte-stream SECDED encoder that sits directly upstream of the Hamming decoder. It accepts 8-bit bytes over a valid/ready handshake, splits each byte into two nibbles, and encodes each nibble into an 8-bit extended-Hamming (8,4) codeword. The codeword bit layout is exactly the one the decoder consumes. It emits one codeword per cycle over a second valid/ready handshake.

---
 rtl/hamming_pkg.sv | 20 ++
 rtl/hamming_encoder_tx_nibble.sv | 32 +++
 rtl/hamming_encoder_tx.sv | 116 +++++++++++
 tb/tb_hamming_encoder_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (8,4) SECDED encoder/decoder pair:
// codeword bit positions and the encoder FSM state type.
package hamming_pkg;

    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D1_POS = 2;
    localparam int P3_POS = 3;
    localparam int D2_POS = 4;
    localparam int D3_POS = 5;
    localparam int D4_POS = 6;
    localparam int P4_POS = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

endpackage

// File: rtl/hamming_encoder_tx_nibble.sv
// Combinational extended-Hamming (8,4) nibble encoder.
// Also reused by the decoder bench as a golden model.
module hamming_nibble_encoder
    import hamming_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] cw
);

    logic d1, d2, d3, d4;
    logic [6:0] low7;

    assign d1 = nibble[0];
    assign d2 = nibble[1];
    assign d3 = nibble[2];
    assign d4 = nibble[3];

    always_comb begin
        low7          = '0;
        low7[P1_POS]  = d1 ^ d2 ^ d4;
        low7[P2_POS]  = d1 ^ d3 ^ d4;
        low7[D1_POS]  = d1;
        low7[P3_POS]  = d2 ^ d3 ^ d4;
        low7[D2_POS]  = d2;
        low7[D3_POS]  = d3;
        low7[D4_POS]  = d4;
    end

    // P4 makes overall parity even so double errors are detectable
    assign cw = {^low7, low7};

endmodule

// File: rtl/hamming_encoder_tx.sv
// Byte-stream SECDED encoder: two codewords per byte over valid/ready.
// Optional error injection ports when HAMMING_ERR_INJECT_EN is defined.
module hamming_encoder_tx
    import hamming_pkg::*;
#(
    parameter int LSN_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       cw_out,
    output logic             cw_valid,
    input  logic             cw_ready,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic             inj_valid,
    input  logic [7:0]       inj_mask,
`endif
    output logic [CNT_W-1:0] cw_count,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [7:0]       byte_q;
    logic [7:0]       cw_q;
    logic [CNT_W-1:0] cnt_q;

    logic       in_hs, cw_hs;
    logic       load_first, load_second;
    logic [3:0] enc_in;
    logic [7:0] enc_cw;
    logic [7:0] cw_d;

    function automatic logic [3:0] first_nib(input logic [7:0] b);
        return (LSN_FIRST != 0) ? b[3:0] : b[7:4];
    endfunction

    function automatic logic [3:0] second_nib(input logic [7:0] b);
        return (LSN_FIRST != 0) ? b[7:4] : b[3:0];
    endfunction

    assign cw_valid = (state_q != IDLE);
    assign busy     = (state_q != IDLE);
    assign in_ready = (state_q == IDLE) || ((state_q == SECOND) && cw_ready);
    assign in_hs    = in_valid && in_ready;
    assign cw_hs    = cw_valid && cw_ready;

    always_comb begin
        state_d     = state_q;
        load_first  = 1'b0;
        load_second = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    load_first = 1'b1;
                    state_d    = FIRST;
                end
            end
            FIRST: begin
                if (cw_hs) begin
                    load_second = 1'b1;
                    state_d     = SECOND;
                end
            end
            SECOND: begin
                if (cw_hs && in_hs) begin
                    load_first = 1'b1;
                    state_d    = FIRST;
                end else if (cw_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single encoder: first nibble comes straight from in_data
    assign enc_in = load_second ? second_nib(byte_q) : first_nib(in_data);

    hamming_nibble_encoder u_enc (
        .nibble (enc_in),
        .cw     (enc_cw)
    );

`ifdef HAMMING_ERR_INJECT_EN
    assign cw_d = enc_cw ^ (inj_valid ? inj_mask : 8'h00);
`else
    assign cw_d = enc_cw;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            byte_q  <= '0;
            cw_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_first) begin
                byte_q <= in_data;
            end
            if (load_first || load_second) begin
                cw_q <= cw_d;
            end
            if (cw_hs) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cw_out   = cw_q;
    assign cw_count = cnt_q;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Directed self-checking bench for hamming_encoder_tx.
// Small counter width so the wrap is reached quickly.
module tb_hamming_encoder_tx;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rstn;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       cw_out;
    logic             cw_valid;
    logic             cw_ready;
    logic [CNT_W-1:0] cw_count;
    logic             busy;
`ifdef HAMMING_ERR_INJECT_EN
    logic             inj_valid;
    logic [7:0]       inj_mask;
`endif

    int checks   = 0;
    int failures = 0;

    logic [CNT_W-1:0] exp_cnt;

    hamming_encoder_tx #(.LSN_FIRST(1), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cw_out   (cw_out),
        .cw_valid (cw_valid),
        .cw_ready (cw_ready),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_valid(inj_valid),
        .inj_mask (inj_mask),
`endif
        .cw_count (cw_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent syndrome decoder: {uncorr, corr, data[3:0]}
    function automatic logic [5:0] decode(input logic [7:0] c);
        logic [2:0] s;
        logic       ov;
        logic [7:0] f;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        ov   = ^c;
        f    = c;
        if (s != 3'd0 && ov) f[s-3'd1] = ~f[s-3'd1];
        return {(s != 3'd0) && !ov, ov, f[6], f[5], f[4], f[2]};
    endfunction

    initial begin
        rstn     = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        cw_ready = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
        inj_valid = 1'b0;
        inj_mask  = 8'h00;
`endif
        exp_cnt = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cw_valid", 32'(cw_valid), 32'd0);
        chk("rst_cw_out",   32'(cw_out),   32'h00);
        chk("rst_count",    32'(cw_count), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        rstn = 1'b1;
        step();

        // single byte 8'h10
        in_data = 8'h10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("b10_first_cw",  32'(cw_out),   32'h00);
        chk("b10_valid",     32'(cw_valid), 32'd1);
        chk("b10_in_ready0", 32'(in_ready), 32'd0);
        chk("b10_busy",      32'(busy),     32'd1);
        step();
        chk("b10_second_cw", 32'(cw_out),   32'h87);
        chk("b10_in_ready1", 32'(in_ready), 32'd1);
        step();
        chk("b10_count",     32'(cw_count), 32'd2);
        chk("b10_idle",      32'(cw_valid), 32'd0);

        // single byte 8'h8F
        in_data = 8'h8F; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("b8f_first_cw",  32'(cw_out), 32'hFF);
        step();
        chk("b8f_second_cw", 32'(cw_out), 32'h4B);
        step();
        chk("b8f_count",     32'(cw_count), 32'd4);

        // back-to-back 8'h01, 8'h08 with no bubble
        in_data = 8'h01; in_valid = 1'b1;
        step();
        in_data = 8'h08;
        chk("b2b_cw0", 32'(cw_out), 32'h87);
        chk("b2b_rdy0", 32'(in_ready), 32'd0);
        step();
        chk("b2b_cw1", 32'(cw_out), 32'h00);
        chk("b2b_rdy1", 32'(in_ready), 32'd1);
        step();
        chk("b2b_cw2", 32'(cw_out), 32'h4B);
        chk("b2b_val2", 32'(cw_valid), 32'd1);
        in_data = 8'hAA;
        step();
        in_valid = 1'b0;
        chk("b2b_cw3", 32'(cw_out), 32'h00);
        chk("b2b_rdy3", 32'(in_ready), 32'd1);
        step();
        chk("b2b_count", 32'(cw_count), 32'd8);
        chk("b2b_idle",  32'(busy), 32'd0);

        // backpressure on byte 8'hF1
        in_data = 8'hF1; in_valid = 1'b1; cw_ready = 1'b0;
        step();
        in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_cw",    32'(cw_out),   32'h87);
            chk("bp_valid", 32'(cw_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_count", 32'(cw_count), 32'd8);
        end

        // asynchronous reset mid-stall
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_cw_valid", 32'(cw_valid), 32'd0);
        chk("arst_cw_out",   32'(cw_out),   32'h00);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_count",    32'(cw_count), 32'd0);
        chk("arst_busy",     32'(busy),     32'd0);
        in_valid = 1'b0; cw_ready = 1'b1;
        step();
        rstn = 1'b1;
        step();
        in_data = 8'h08; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_cw0", 32'(cw_out), 32'h4B);
        step();
        chk("post_rst_cw1", 32'(cw_out), 32'h00);
        step();
        chk("post_rst_count", 32'(cw_count), 32'd2);
        exp_cnt = 4'd2;

        // exhaustive loopback through an independent decoder
        for (int b = 0; b < 256; b++) begin
            logic [7:0] bv;
            bv = 8'(b);
            in_data = bv; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("lb_lo", 32'(decode(cw_out)), {26'd0, 2'b00, bv[3:0]});
            step();
            exp_cnt = exp_cnt + 1'b1;
            chk("lb_cnt1", 32'(cw_count), 32'(exp_cnt));
            chk("lb_hi", 32'(decode(cw_out)), {26'd0, 2'b00, bv[7:4]});
            step();
            exp_cnt = exp_cnt + 1'b1;
            chk("lb_cnt2", 32'(cw_count), 32'(exp_cnt));
            if (exp_cnt == '0 || exp_cnt == 4'd1)
                chk("lb_wrap", 32'(cw_count), 32'(exp_cnt));
        end

`ifdef HAMMING_ERR_INJECT_EN
        // single-bit injection on nibble 1
        in_data = 8'h01; in_valid = 1'b1;
        inj_valid = 1'b1; inj_mask = 8'h04;
        step();
        in_valid = 1'b0; inj_valid = 1'b0;
        chk("inj1_cw",  32'(cw_out), 32'h83);
        chk("inj1_dec", 32'(decode(cw_out)), {26'd0, 2'b01, 4'h1});
        step();
        chk("inj1_clean", 32'(cw_out), 32'h00);
        step();
        exp_cnt = exp_cnt + 2'd2;
        chk("inj1_count", 32'(cw_count), 32'(exp_cnt));
        // double-bit injection
        in_data = 8'h01; in_valid = 1'b1;
        inj_valid = 1'b1; inj_mask = 8'h06;
        step();
        in_valid = 1'b0; inj_valid = 1'b0;
        chk("inj2_cw", 32'(cw_out), 32'h81);
        chk("inj2_unc", 32'(decode(cw_out) >> 5), 32'd1);
        step();
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
